// File: rtl/alu_issue_scheduler.sv
// Issue scheduler for the ALU issue queue.
// A collapsing queue (slot 0 = oldest) buffers dispatched uops and tracks
// operand readiness through writeback wakeups. Each cycle it picks the oldest
// eligible uop and presents it on a single valid/ready issue port.
module alu_issue_scheduler #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [5:0]                   enq_uopcode,
    input  logic [1:0]                   enq_exu,
    input  logic                         enq_has_rs1,
    input  logic                         enq_has_rs2,
    input  logic [4:0]                   enq_rs1,
    input  logic [4:0]                   enq_rs2,
    input  logic                         enq_rs1_rdy,
    input  logic                         enq_rs2_rdy,
    input  logic [PAYLOAD_W-1:0]         enq_payload,
    input  logic                         wb_valid,
    input  logic [4:0]                   wb_rd,
    input  logic                         div_ready,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [5:0]                   iss_uopcode,
    output logic [1:0]                   iss_exu,
    output logic [PAYLOAD_W-1:0]         iss_payload,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // Execute-unit encoding
    localparam logic [1:0] EXU_ALU = 2'd0;
    localparam logic [1:0] EXU_MUL = 2'd1;
    localparam logic [1:0] EXU_DIV = 2'd2;
    localparam logic [1:0] EXU_MEM = 2'd3;

    // Registered queue state
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [CW-1:0]        count_q, count_d;
    logic [5:0]           uop_q     [DEPTH];
    logic [5:0]           uop_d     [DEPTH];
    logic [1:0]           exu_q     [DEPTH];
    logic [1:0]           exu_d     [DEPTH];
    logic [4:0]           rs1_q     [DEPTH];
    logic [4:0]           rs1_d     [DEPTH];
    logic [4:0]           rs2_q     [DEPTH];
    logic [4:0]           rs2_d     [DEPTH];
    logic [DEPTH-1:0]     r1_q, r1_d;
    logic [DEPTH-1:0]     r2_q, r2_d;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];

    // Per-cycle control
    logic [DEPTH-1:0] elig;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic             fire;
    logic             enq_fire;
    logic             wb_hit;
    logic             enq_r1, enq_r2;
    logic [CW-1:0]    cnt_after;

    assign enq_ready = (count_q < CW'(DEPTH));
    assign count     = count_q;
    assign wb_hit    = wb_valid && (wb_rd != 5'd0);
    assign fire      = iss_valid && iss_ready;
    assign enq_fire  = enq_valid && enq_ready && !flush && (enq_exu != EXU_MEM);

    // Readiness at dispatch, including a same-cycle writeback bypass
    assign enq_r1 = !enq_has_rs1 || (enq_rs1 == 5'd0) || enq_rs1_rdy || (wb_hit && (wb_rd == enq_rs1));
    assign enq_r2 = !enq_has_rs2 || (enq_rs2 == 5'd0) || enq_rs2_rdy || (wb_hit && (wb_rd == enq_rs2));

    // Eligibility and oldest-first selection
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = valid_q[i] && r1_q[i] && r2_q[i] && ((exu_q[i] != EXU_DIV) || div_ready);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end

    assign iss_valid   = win_found;
    assign iss_uopcode = win_found ? uop_q[win_idx]     : '0;
    assign iss_exu     = win_found ? exu_q[win_idx]     : '0;
    assign iss_payload = win_found ? payload_q[win_idx] : '0;

    // Next state: collapse over the issued slot, apply wakeup, then enqueue
    always_comb begin
        int src;
        cnt_after = count_q - CW'(fire);
        for (int i = 0; i < DEPTH; i++) begin
            src = (fire && (i >= int'(win_idx))) ? i + 1 : i;
            if (src >= DEPTH) begin
                src        = DEPTH - 1;
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[src];
            end
            uop_d[i]     = uop_q[src];
            exu_d[i]     = exu_q[src];
            rs1_d[i]     = rs1_q[src];
            rs2_d[i]     = rs2_q[src];
            payload_d[i] = payload_q[src];
            r1_d[i]      = r1_q[src] || (wb_hit && (rs1_q[src] == wb_rd));
            r2_d[i]      = r2_q[src] || (wb_hit && (rs2_q[src] == wb_rd));
            if (enq_fire && (CW'(i) == cnt_after)) begin
                valid_d[i]   = 1'b1;
                uop_d[i]     = enq_uopcode;
                exu_d[i]     = enq_exu;
                rs1_d[i]     = enq_rs1;
                rs2_d[i]     = enq_rs2;
                payload_d[i] = enq_payload;
                r1_d[i]      = enq_r1;
                r2_d[i]      = enq_r2;
            end
        end
        count_d = count_q - CW'(fire) + CW'(enq_fire);
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // Control state: occupancy and valid bits
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage
    always_ff @(posedge clk) begin
        // NOTE: entry fields are not reset; they are masked by valid_q and never observed while invalid.
        for (int i = 0; i < DEPTH; i++) begin
            uop_q[i]     <= uop_d[i];
            exu_q[i]     <= exu_d[i];
            rs1_q[i]     <= rs1_d[i];
            rs2_q[i]     <= rs2_d[i];
            payload_q[i] <= payload_d[i];
        end
        r1_q <= r1_d;
        r2_q <= r2_d;
    end

    // The memory unit is never legal on this queue
    a_no_mem_enq: assert property (@(posedge clk) disable iff (rst)
        !(enq_valid && enq_ready && !flush && (enq_exu == EXU_MEM)));

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: stimulus pushes expected issues,
// a negedge monitor pops and compares every completed issue handshake.
module tb_alu_issue_scheduler;

    localparam int DEPTH = 8;
    localparam int PW    = 32;

    localparam logic [1:0] ALU = 2'd0;
    localparam logic [1:0] MUL = 2'd1;
    localparam logic [1:0] DIV = 2'd2;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd3;
    localparam logic [5:0] OP_MUL  = 6'd4;
    localparam logic [5:0] OP_DIV  = 6'd5;

    logic          clk = 1'b0;
    logic          rst, flush, enq_valid, enq_ready;
    logic [5:0]    enq_uopcode;
    logic [1:0]    enq_exu;
    logic          enq_has_rs1, enq_has_rs2, enq_rs1_rdy, enq_rs2_rdy;
    logic [4:0]    enq_rs1, enq_rs2, wb_rd;
    logic [PW-1:0] enq_payload, iss_payload;
    logic          wb_valid, div_ready, iss_valid, iss_ready;
    logic [5:0]    iss_uopcode;
    logic [1:0]    iss_exu;
    logic [3:0]    count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [5:0]    uop;
        logic [1:0]    exu;
        logic [PW-1:0] pl;
    } exp_t;
    exp_t sb[$];

    alu_issue_scheduler #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_uopcode(enq_uopcode), .enq_exu(enq_exu),
        .enq_has_rs1(enq_has_rs1), .enq_has_rs2(enq_has_rs2),
        .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
        .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
        .enq_payload(enq_payload),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .div_ready(div_ready),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_uopcode(iss_uopcode), .iss_exu(iss_exu), .iss_payload(iss_payload),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] uop, input logic [1:0] exu, input logic [PW-1:0] pl);
        exp_t e;
        e.uop = uop;
        e.exu = exu;
        e.pl  = pl;
        sb.push_back(e);
    endtask

    // One-cycle enqueue offer
    task automatic enq(input logic [5:0] uop, input logic [1:0] exu,
                       input logic h1, input logic [4:0] r1, input logic y1,
                       input logic h2, input logic [4:0] r2, input logic y2,
                       input logic [PW-1:0] pl);
        enq_valid   = 1'b1;
        enq_uopcode = uop;
        enq_exu     = exu;
        enq_has_rs1 = h1;
        enq_rs1     = r1;
        enq_rs1_rdy = y1;
        enq_has_rs2 = h2;
        enq_rs2     = r2;
        enq_rs2_rdy = y2;
        enq_payload = pl;
        tick();
        enq_valid   = 1'b0;
    endtask

    // Monitor: compare every completed issue against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (iss_valid && iss_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL issue_unexpected: got payload 0x%0h with empty scoreboard", iss_payload);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("issue_uopcode", 32'(iss_uopcode), 32'(e.uop));
                    check("issue_exu", 32'(iss_exu), 32'(e.exu));
                    check("issue_payload", iss_payload, e.pl);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_uopcode = '0; enq_exu = '0;
        enq_has_rs1 = 1'b0; enq_has_rs2 = 1'b0; enq_rs1 = '0; enq_rs2 = '0;
        enq_rs1_rdy = 1'b0; enq_rs2_rdy = 1'b0; enq_payload = '0;
        wb_valid = 1'b0; wb_rd = '0; div_ready = 1'b1; iss_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_iss_valid", 32'(iss_valid), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_iss_uopcode", 32'(iss_uopcode), 32'd0);
        check("rst_iss_exu", 32'(iss_exu), 32'd0);
        check("rst_iss_payload", iss_payload, 32'd0);

        // Ready add issues the cycle after enqueue
        enq(OP_ADD, ALU, 1, 5'd1, 1, 1, 5'd2, 1, 32'h100);
        check("t1_iss_valid", 32'(iss_valid), 32'd1);
        check("t1_iss_uopcode", 32'(iss_uopcode), 32'(OP_ADD));
        check("t1_count", 32'(count), 32'd1);
        push(OP_ADD, ALU, 32'h100);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t1_count_after", 32'(count), 32'd0);
        check("t1_iss_valid_after", 32'(iss_valid), 32'd0);

        // Younger ready uop bypasses older blocked one; wakeup releases it
        enq(OP_SUB, ALU, 1, 5'd5, 0, 0, 5'd0, 0, 32'h200);
        enq(OP_ADDI, ALU, 1, 5'd6, 1, 0, 5'd0, 0, 32'h201);
        check("t2_bypass_payload", iss_payload, 32'h201);
        push(OP_ADDI, ALU, 32'h201);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t2_blocked_valid", 32'(iss_valid), 32'd0);
        check("t2_count", 32'(count), 32'd1);
        wb_valid = 1'b1; wb_rd = 5'd5; tick(); wb_valid = 1'b0;
        check("t2_wakeup_valid", 32'(iss_valid), 32'd1);
        check("t2_wakeup_payload", iss_payload, 32'h200);
        push(OP_SUB, ALU, 32'h200);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t2_count_after", 32'(count), 32'd0);

        // Blocked div is bypassed by mul until div_ready rises
        div_ready = 1'b0;
        enq(OP_DIV, DIV, 1, 5'd3, 1, 1, 5'd4, 1, 32'h300);
        enq(OP_MUL, MUL, 1, 5'd3, 1, 1, 5'd4, 1, 32'h301);
        check("t3_mul_selected", iss_payload, 32'h301);
        push(OP_MUL, MUL, 32'h301);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t3_div_blocked", 32'(iss_valid), 32'd0);
        check("t3_count", 32'(count), 32'd1);
        div_ready = 1'b1;
        push(OP_DIV, DIV, 32'h300);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t3_count_after", 32'(count), 32'd0);

        // Fill to DEPTH, refused enqueue when full, then issue+enqueue at 7
        for (int i = 0; i < DEPTH; i++) begin
            enq(OP_ADD, ALU, 0, 5'd0, 0, 0, 5'd0, 0, 32'h400 + i);
        end
        check("t4_full_ready", 32'(enq_ready), 32'd0);
        check("t4_full_count", 32'(count), 32'd8);
        push(OP_ADD, ALU, 32'h400);
        iss_ready = 1'b1;
        enq(OP_SUB, ALU, 0, 5'd0, 0, 0, 5'd0, 0, 32'h4FF);
        check("t4_refused_count", 32'(count), 32'd7);
        push(OP_ADD, ALU, 32'h401);
        enq(OP_SUB, ALU, 0, 5'd0, 0, 0, 5'd0, 0, 32'h410);
        iss_ready = 1'b0;
        check("t4_swap_count", 32'(count), 32'd7);
        for (int i = 2; i < DEPTH; i++) push(OP_ADD, ALU, 32'h400 + i);
        push(OP_SUB, ALU, 32'h410);
        iss_ready = 1'b1;
        repeat (7) tick();
        iss_ready = 1'b0;
        check("t4_drained", 32'(count), 32'd0);

        // x0 source is always ready; wb_rd=0 wakes nothing; enqueue-time wb bypass
        enq(OP_SUB, ALU, 1, 5'd1, 1, 1, 5'd0, 0, 32'h500);
        check("t5_x0_ready", 32'(iss_valid), 32'd1);
        push(OP_SUB, ALU, 32'h500);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        enq(OP_ADD, ALU, 1, 5'd7, 0, 0, 5'd0, 0, 32'h501);
        wb_valid = 1'b1; wb_rd = 5'd0; tick(); wb_valid = 1'b0;
        check("t5_wb_x0_nowake", 32'(iss_valid), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd7;
        enq(OP_ADDI, ALU, 1, 5'd7, 0, 0, 5'd0, 0, 32'h502);
        wb_valid = 1'b0;
        check("t5_wake_payload", iss_payload, 32'h501);
        check("t5_count", 32'(count), 32'd2);
        push(OP_ADD, ALU, 32'h501);
        push(OP_ADDI, ALU, 32'h502);
        iss_ready = 1'b1; tick(); tick(); iss_ready = 1'b0;
        check("t5_count_after", 32'(count), 32'd0);

        // Flush with a same-cycle enqueue drops everything
        for (int i = 0; i < 5; i++) begin
            enq(OP_ADD, ALU, 0, 5'd0, 0, 0, 5'd0, 0, 32'h600 + i);
        end
        check("t6_count_5", 32'(count), 32'd5);
        flush = 1'b1;
        enq(OP_ADD, ALU, 0, 5'd0, 0, 0, 5'd0, 0, 32'h6FF);
        flush = 1'b0;
        check("t6_flush_count", 32'(count), 32'd0);
        check("t6_flush_valid", 32'(iss_valid), 32'd0);
        tick();
        check("t6_enq_dropped", 32'(count), 32'd0);

        repeat (2) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
